// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory port, decode-side controls and the IF/ID register outputs.
interface fetch_if #(
  parameter int unsigned ADDR_W = 64
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              stall;
  logic              br_taken;
  logic              uncond_br;
  logic [ADDR_W-1:0] if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [10:0]       opCode;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  br_taken,
    input  uncond_br,
    output if_id_pc,
    output if_id_instr,
    output if_id_valid,
    output opCode
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output br_taken,
    output uncond_br,
    input  if_id_pc,
    input  if_id_instr,
    input  if_id_valid,
    input  opCode
  );
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: PC, IF/ID register, decode-resolved branch redirect and stall.
// Optional fetch/flush counters are enabled with the FETCH_STATS_EN macro.
module fetch_unit #(
  parameter int unsigned           ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic       clk,
  input  logic       reset,
  fetch_if.master    bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [31:0]       NOP     = 32'h910003FF;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_target;
  logic              redirect;
  logic              load_valid;

  // Branch target from the instruction held in IF/ID; a squashed slot never redirects.
  always_comb begin
    br_offset = bus.uncond_br
              ? {{(ADDR_W-26){if_id_instr_q[25]}}, if_id_instr_q[25:0]}
              : {{(ADDR_W-19){if_id_instr_q[23]}}, if_id_instr_q[23:5]};
    br_target = if_id_pc_q + {br_offset[ADDR_W-3:0], 2'b00};
    redirect  = bus.br_taken && if_id_valid_q && !bus.stall;
    load_valid = !bus.stall && !redirect;
  end

  always_comb begin
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    if (redirect) begin
      pc_d          = br_target;
      if_id_pc_d    = pc_q;
      if_id_instr_d = NOP;
      if_id_valid_d = 1'b0;
    end else if (load_valid) begin
      pc_d          = pc_q + PC_STEP;
      if_id_pc_d    = pc_q;
      if_id_instr_d = bus.imem_rdata;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.opCode      = if_id_instr_q[31:21];

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Saturating event counters; a stall produces neither event so both hold.
  always_comb begin
    fetch_count_d = fetch_count_q;
    flush_count_d = flush_count_q;
    if (load_valid && (fetch_count_q != 32'hFFFFFFFF)) fetch_count_d = fetch_count_q + 32'd1;
    if (redirect && (flush_count_q != 32'hFFFFFFFF))   flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (counter checks only when FETCH_STATS_EN is defined).
module tb_fetch_unit;

  localparam logic [31:0] NOP    = 32'h910003FF;
  localparam logic [10:0] NOP_OP = 11'b10010001000;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fetch_if #(.ADDR_W(64)) bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a few planted branches, otherwise an address-derived word.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   mem_word = 32'h17FFFFFF;  // B  imm26 = -1
      64'h8:   mem_word = 32'h54000060;  // B.cond imm19 = +3
      64'h100: mem_word = 32'h17FFFFC0;  // B  imm26 = -64
      default: mem_word = {4'hA, a[27:0]};
    endcase
  endfunction

  always_comb bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    bus.uncond_br = 1'b0;
    tick();
    tick();
    check("rst_addr",  bus.imem_addr, 64'h0);
    check("rst_valid", 64'(bus.if_id_valid), 64'h0);
    check("rst_instr", 64'(bus.if_id_instr), 64'(NOP));
    check("rst_ifpc",  bus.if_id_pc, 64'h0);
    check("rst_op",    64'(bus.opCode), 64'(NOP_OP));

    // Sequential fetch
    reset = 1'b0;
    tick();
    check("seq1_addr",  bus.imem_addr, 64'h4);
    check("seq1_valid", 64'(bus.if_id_valid), 64'h1);
    check("seq1_ifpc",  bus.if_id_pc, 64'h0);
    tick();
    check("seq2_addr",  bus.imem_addr, 64'h8);
    check("seq2_ifpc",  bus.if_id_pc, 64'h4);
    tick();
    check("seq3_addr",  bus.imem_addr, 64'hC);
    check("seq3_instr", 64'(bus.if_id_instr), 64'h54000060);

    // Conditional branch at 0x8, imm19 = +3 -> 0x14
    bus.br_taken = 1'b1;
    bus.uncond_br = 1'b0;
    tick();
    check("cb_addr",  bus.imem_addr, 64'h14);
    check("cb_instr", 64'(bus.if_id_instr), 64'(NOP));
    check("cb_valid", 64'(bus.if_id_valid), 64'h0);
    check("cb_op",    64'(bus.opCode), 64'(NOP_OP));
    check("cb_ifpc",  bus.if_id_pc, 64'hC);
    // br_taken still high on the squashed slot: must not redirect
    tick();
    check("sq_addr",  bus.imem_addr, 64'h18);
    check("sq_valid", 64'(bus.if_id_valid), 64'h1);
    check("sq_ifpc",  bus.if_id_pc, 64'h14);
    bus.br_taken = 1'b0;

    // Run sequentially up to 0x100, then take B -64
    for (int i = 0; i < 100 && bus.imem_addr != 64'h100; i++) tick();
    check("reach_100", bus.imem_addr, 64'h100);
    tick();
    check("b_instr", 64'(bus.if_id_instr), 64'h17FFFFC0);
    bus.br_taken = 1'b1;
    bus.uncond_br = 1'b1;
    tick();
    check("b_addr",  bus.imem_addr, 64'h0);
    check("b_valid", 64'(bus.if_id_valid), 64'h0);
    bus.br_taken = 1'b0;
    tick();
    check("b_resume_addr",  bus.imem_addr, 64'h4);
    check("b_resume_ifpc",  bus.if_id_pc, 64'h0);
    check("b_resume_valid", 64'(bus.if_id_valid), 64'h1);

    // Stall with br_taken asserted: frozen, then redirect once stall drops
    tick();
    tick();
    check("pre_stall_ifpc", bus.if_id_pc, 64'h8);
    bus.stall = 1'b1;
    bus.br_taken = 1'b1;
    bus.uncond_br = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr",  bus.imem_addr, 64'hC);
      check("stall_ifpc",  bus.if_id_pc, 64'h8);
      check("stall_valid", 64'(bus.if_id_valid), 64'h1);
    end
    bus.stall = 1'b0;
    tick();
    check("unstall_addr",  bus.imem_addr, 64'h14);
    check("unstall_valid", 64'(bus.if_id_valid), 64'h0);

    // Reset wins over a live redirect
    bus.br_taken = 1'b0;
    tick();
    check("pre_rst_valid", 64'(bus.if_id_valid), 64'h1);
    reset = 1'b1;
    bus.br_taken = 1'b1;
    tick();
    check("rstbr_addr",  bus.imem_addr, 64'h0);
    check("rstbr_valid", 64'(bus.if_id_valid), 64'h0);
    check("rstbr_instr", 64'(bus.if_id_instr), 64'(NOP));

    // B -1 from 0 lands at the top word, next fetch wraps to 0
    reset = 1'b0;
    bus.br_taken = 1'b0;
    tick();
    bus.br_taken = 1'b1;
    bus.uncond_br = 1'b1;
    tick();
    check("top_addr", bus.imem_addr, 64'hFFFFFFFFFFFFFFFC);
    bus.br_taken = 1'b0;
    tick();
    check("wrap_addr",  bus.imem_addr, 64'h0);
    check("wrap_ifpc",  bus.if_id_pc, 64'hFFFFFFFFFFFFFFFC);
    check("wrap_valid", 64'(bus.if_id_valid), 64'h1);

`ifdef FETCH_STATS_EN
    reset = 1'b1;
    tick();
    check("cnt_rst_fetch", 64'(fetch_count), 64'h0);
    check("cnt_rst_flush", 64'(flush_count), 64'h0);
    reset = 1'b0;
    bus.uncond_br = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    bus.br_taken = 1'b1;
    tick();
    bus.br_taken = 1'b0;
    tick();
    bus.br_taken = 1'b1;
    tick();
    bus.br_taken = 1'b0;
    check("cnt_fetch", 64'(fetch_count), 64'd10);
    check("cnt_flush", 64'(flush_count), 64'd2);
    force dut.fetch_count_q = 32'hFFFFFFFF;
    force dut.flush_count_q = 32'hFFFFFFFF;
    #1;
    release dut.fetch_count_q;
    release dut.flush_count_q;
    tick();
    bus.br_taken = 1'b1;
    tick();
    bus.br_taken = 1'b0;
    check("sat_fetch", 64'(fetch_count), 64'hFFFFFFFF);
    check("sat_flush", 64'(flush_count), 64'hFFFFFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
